// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - state encoding, default sizing and helpers shared by bus_arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_WAIT_CYCLES = 1;
  // wide enough for the largest legal WAIT_CYCLES (7)
  localparam int CNT_W           = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting after the last granted master
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  // scan upward from last_grant+1, wrapping at N_REQ, and take the first requester
  always_comb begin
    int idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[IW'(idx)]) begin
        pick[IW'(idx)] = 1'b1;
        valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin memory bus arbiter with fixed-latency access (optional BUS_ARB_LOCK_EN)
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
`ifdef BUS_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   lock,
`endif
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      mem_address,
  output logic               mem_r,
  output logic               mem_w,
  inout  wire  [DW-1:0]      mem_data
);

  localparam int IW = idx_width(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]    grant_q;
  logic [IW-1:0]       owner_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IW-1:0]       last_q;
  logic [DW-1:0]       rdata_q;

  logic [N_REQ-1:0]    pick;
  logic                pick_valid;
  logic [N_REQ-1:0]    sel;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req        (req),
    .last_grant (last_q),
    .pick       (pick),
    .valid      (pick_valid)
  );

`ifdef BUS_ARB_LOCK_EN
  logic lock_q;
  logic hold;

  // a locked owner that is still requesting wins the next arbitration outright
  assign hold = lock_q && req[owner_q];

  // choose between the locked owner and the round-robin pick
  always_comb begin
    sel       = pick;
    sel_valid = pick_valid;
    if (hold) begin
      sel       = ONE << owner_q;
      sel_valid = 1'b1;
    end
  end

  // lock is re-evaluated at DONE and dropped when the owner stops requesting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else if (state_q == DONE) begin
      lock_q <= lock[owner_q];
    end else if (state_q == IDLE && lock_q && !req[owner_q]) begin
      lock_q <= 1'b0;
    end
  end
`else
  assign sel       = pick;
  assign sel_valid = pick_valid;
`endif

  // one-hot selection to index, used for payload muxing and the pointer
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state and bus strobes; everything is zero outside ACCESS/DONE
  always_comb begin
    state_d     = state_q;
    mem_address = '0;
    mem_r       = 1'b0;
    mem_w       = 1'b0;
    ack         = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_address = addr_q;
        mem_r       = !we_q;
        mem_w       = we_q;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        ack     = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // grant, payload latch, wait counter, read capture and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            grant_q <= sel;
            owner_q <= sel_idx;
            addr_q  <= addr[sel_idx*AW +: AW];
            wdata_q <= wdata[sel_idx*DW +: DW];
            we_q    <= we[sel_idx];
            cnt_q   <= CNT_W'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1) && !we_q) rdata_q <= mem_data;
        end
        DONE: begin
          grant_q <= '0;
`ifdef BUS_ARB_LOCK_EN
          if (!lock[owner_q]) last_q <= owner_q;
`else
          last_q <= owner_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign grant    = grant_q;
  assign rdata    = rdata_q;
  assign mem_data = mem_w ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized self-checking bench for bus_arbiter with a transaction-level model
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 1;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    we    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;
`ifdef BUS_ARB_LOCK_EN
  logic [N-1:0]    lock  = '0;
`endif
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_address;
  logic            mem_r;
  logic            mem_w;
  wire  [DW-1:0]   mem_data;

  logic [DW-1:0]   env_mem [16];
  logic [DW-1:0]   ref_mem [16];

  assign mem_data = mem_r ? env_mem[mem_address[3:0]] : {DW{1'bz}};

  bus_arbiter #(
    .N_REQ       (N),
    .WAIT_CYCLES (W),
    .AW          (AW),
    .DW          (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
`ifdef BUS_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .ack         (ack),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .mem_data    (mem_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // transaction-level reference state
  bit            tx_on;
  int            age;
  int            tx_owner;
  logic [AW-1:0] tx_addr;
  logic          tx_we;
  logic [DW-1:0] tx_wdata;
  int            ptr;
  logic [DW-1:0] exp_rdata;
  bit            locked;

  bit            pend_w;
  logic [3:0]    pend_a;
  logic [DW-1:0] pend_d;

  logic [N-1:0]  rise_g [$];
  int            rise_t [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    tx_on     = 1'b0;
    age       = 0;
    tx_owner  = 0;
    ptr       = N - 1;
    exp_rdata = '0;
    locked    = 1'b0;
  endtask

  task automatic model_edge();
    int win;
    win = -1;
    if (tx_on) begin
      age++;
      if (age == W + 1) begin
        if (tx_we) ref_mem[tx_addr[3:0]] = tx_wdata;
        else       exp_rdata = ref_mem[tx_addr[3:0]];
      end else if (age == W + 2) begin
        tx_on = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        if (lock[tx_owner]) locked = 1'b1;
        else begin
          locked = 1'b0;
          ptr    = tx_owner;
        end
`else
        ptr = tx_owner;
`endif
      end
    end else begin
      if (locked && req[tx_owner]) win = tx_owner;
      else locked = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (win < 0 && req[(ptr + k) % N]) win = (ptr + k) % N;
      end
      if (win >= 0) begin
        tx_on    = 1'b1;
        age      = 1;
        tx_owner = win;
        tx_addr  = addr[win*AW +: AW];
        tx_we    = we[win];
        tx_wdata = wdata[win*DW +: DW];
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0]  eg;
    logic [N-1:0]  ea;
    logic          er;
    logic          ew;
    logic [AW-1:0] eaddr;
    eg = '0; ea = '0; er = 1'b0; ew = 1'b0; eaddr = '0;
    if (tx_on && age <= W) begin
      eg[tx_owner] = 1'b1;
      er    = !tx_we;
      ew    = tx_we;
      eaddr = tx_addr;
    end else if (tx_on && age == W + 1) begin
      eg[tx_owner] = 1'b1;
      ea[tx_owner] = 1'b1;
    end
    check_val("grant", 32'(grant), 32'(eg));
    check_val("ack", 32'(ack), 32'(ea));
    check_val("mem_r", 32'(mem_r), 32'(er));
    check_val("mem_w", 32'(mem_w), 32'(ew));
    check_val("mem_address", 32'(mem_address), 32'(eaddr));
    if (ew) check_val("mem_data", 32'(mem_data), 32'(tx_wdata));
    check_val("rdata", 32'(rdata), 32'(exp_rdata));
    if (mem_w) begin
      pend_w = 1'b1;
      pend_a = mem_address[3:0];
      pend_d = mem_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (pend_w) env_mem[pend_a] = pend_d;
    pend_w = 1'b0;
    if (!reset) model_reset();
    else        model_edge();
    #1;
    cyc++;
    compare();
  endtask

  task automatic mid_reset();
    #2;
    reset  = 1'b0;
    pend_w = 1'b0;
    model_reset();
    #1;
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_mem_r", 32'(mem_r), 32'd0);
    check_val("rst_mem_w", 32'(mem_w), 32'd0);
    check_val("rst_mem_address", 32'(mem_address), 32'd0);
    check_val("rst_rdata", 32'(rdata), 32'd0);
    #1;
    reset = 1'b1;
  endtask

  task automatic collect(input int nwant, input int maxt);
    logic [N-1:0] prev;
    rise_g.delete();
    rise_t.delete();
    prev = grant;
    for (int t = 0; t < maxt && rise_g.size() < nwant; t++) begin
      tick();
      if (grant != '0 && prev == '0) begin
        rise_g.push_back(grant);
        rise_t.push_back(cyc);
      end
      prev = grant;
    end
    check_val("collect_count", 32'(rise_g.size()), 32'(nwant));
  endtask

  initial begin
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] rq;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      env_mem[i] = ref_mem[i];
    end
    ref_mem[3] = 16'hBEEF;
    env_mem[3] = 16'hBEEF;
    pend_w = 1'b0;
    pend_a = '0;
    pend_d = '0;
    model_reset();

    // reset state
    tick();
    tick();
    reset = 1'b1;

    // single read by master 0
    req = 4'b0001;
    we  = 4'b0000;
    addr[0 +: AW] = 16'h0123;
    tick();
    check_val("t1_grant", 32'(grant), 32'h1);
    check_val("t1_addr", 32'(mem_address), 32'h0123);
    check_val("t1_mem_r", 32'(mem_r), 32'h1);
    req = 4'b0000;
    tick();
    check_val("t1_ack", 32'(ack), 32'h1);
    check_val("t1_rdata", 32'(rdata), 32'hBEEF);
    tick();

    // all masters requesting: strict rotation from master 0
    mid_reset();
    req = 4'b1111;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    collect(5, 20);
    for (int i = 0; i < rise_g.size(); i++) begin
      check_val("t2_order", 32'(rise_g[i]), 32'(exp_seq[i]));
      if (i > 0) check_val("t2_gap", 32'(rise_t[i] - rise_t[i-1]), 32'(W + 2));
    end
    req = 4'b0000;
    tick();
    tick();

    // master 2 write, payload changed right after grant
    req = 4'b0100;
    we  = 4'b0100;
    addr[2*AW +: AW]  = 16'h07FF;
    wdata[2*DW +: DW] = 16'h55AA;
    tick();
    req = 4'b0000;
    addr[2*AW +: AW]  = 16'h1234;
    wdata[2*DW +: DW] = 16'h0000;
    #1;
    check_val("t3_grant", 32'(grant), 32'h4);
    check_val("t3_mem_w", 32'(mem_w), 32'h1);
    check_val("t3_addr", 32'(mem_address), 32'h07FF);
    check_val("t3_data", 32'(mem_data), 32'h55AA);
    tick();
    check_val("t3_ack", 32'(ack), 32'h4);
    tick();
    check_val("t3_mem", 32'(env_mem[15]), 32'h55AA);
    we = 4'b0000;

    // reset during ACCESS aborts the access and restores master-0 priority
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0100;
    tick();
    mid_reset();
    req = 4'b0011;
    tick();
    check_val("t4_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    tick();

    // master 1 drops req after grant, ack still issued
    req = 4'b0010;
    tick();
    check_val("t5_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    check_val("t5_ack", 32'(ack), 32'h2);
    tick();

`ifdef BUS_ARB_LOCK_EN
    // locked master 1 keeps winning until its lock bit is cleared at DONE
    mid_reset();
    lock = 4'b0010;
    req  = 4'b0011;
    collect(5, 25);
    for (int i = 0; i < rise_g.size(); i++) begin
      check_val("t6_locked", 32'(rise_g[i]), (i == 0) ? 32'h1 : 32'h2);
    end
    lock = 4'b0000;
    collect(2, 12);
    if (rise_g.size() > 0) check_val("t6_release", 32'(rise_g[0]), 32'h1);
    req = 4'b0000;
    tick();
    tick();
    tick();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        rq = '0;
        for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 9) < 4);
        req = rq;
      end
      we = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          addr[i*AW +: AW]  = 16'($urandom);
          wdata[i*DW +: DW] = 16'($urandom);
        end
      end
`ifdef BUS_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = 4'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) mid_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
